fp_addsub_pipe: RTL and testbench
=================================

# fp_addsub_pipe

Parametrised, pipelined IEEE-754 floating-point adder/subtractor with a valid/ready stream interface. It is the next-generation add/sub datapath of the FP ALU. Over the previous generation it adds an add/subtract select, exponent-width/mantissa-width generalisation, normalisation, round-to-nearest-even, special-value handling, exception flags, and three-stage pipelining with backpressure.

## Interface
- EXP_WIDTH, 8, exponent field width (≥ 4)
- MANT_WIDTH, 23, stored fraction width (≥ 4); WIDTH = 1+EXP_WIDTH+MANT_WIDTH (derived localparam, 32 at defaults)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts beat this cycle
- a  in  WIDTH  operand A, IEEE-754 packed
- b  in  WIDTH  operand B, IEEE-754 packed
- op  in  1  0: a+b, 1: a−b
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  packed IEEE-754 result
- flags  out  4  {invalid, overflow, underflow, inexact}, aligned with result

## Operation
- Effective sign of B = b.sign XOR op. Effective subtract when sign A ≠ effective sign B.
- Denormal inputs (exp==0) are flushed to signed zero. No denormal is ever produced.
- Stage 1 (unpack/align):
  - Classify zero/inf/NaN.
  - Swap so the larger-magnitude operand (compare {exp,frac}) is X.
  - Extend mantissas to hidden+MANT_WIDTH+3 bits (guard, round, sticky).
  - Right-shift Y by the exponent difference; shifted-out bits OR into sticky.
  - If the difference is ≥ MANT_WIDTH+3, Y reduces to sticky only.
- Stage 2 (add/sub): mantissa sum or difference at MANT_WIDTH+5 bits (carry bit). Result sign = sign of X.
- Stage 3 (normalise/round/pack):
  - On carry-out, right-shift 1 with sticky and increment the exponent.
  - Otherwise, left-shift by the leading-zero count and decrement the exponent.
  - Round to nearest, ties to even, using G/R/S. A rounding carry renormalises.
  - Exponent ≥ all-ones → ±Inf with overflow=1 and inexact=1.
  - Exponent ≤ 0 → signed zero with underflow=1 and inexact=1.
  - inexact=1 whenever any of G/R/S is nonzero before rounding.
- Special cases (override datapath):
  - Any NaN input → canonical qNaN (sign 0, exp all ones, frac MSB 1, rest 0). invalid=1 only if an input is signalling (frac MSB 0).
  - Inf − Inf (effective) → canonical qNaN, invalid=1.
  - Inf ± finite → that Inf.
  - Exact zero from effective subtract → +0.
  - (+0)+(+0) → +0; (−0)+(−0) → −0; mixed-sign zeros → +0.

## Timing
- Latency: exactly 3 cycles from accepted beat (in_valid & in_ready at edge N) to out_valid at edge N+3, provided there is no stall. Throughput is 1 beat/cycle.
- Global enable en = ~out_valid | out_ready. in_ready = en (combinational).
- When en=0, all stage registers hold.
- Bubbles propagate as valid=0. Order is strictly preserved.
- result and flags are stable while out_valid & ~out_ready. No beat is ever lost or duplicated.
- in_valid while in_ready=0 is ignored; the upstream must hold.
- Reset values: out_valid=0, result=0, flags=0, all internal stage valids=0. in_ready=1 after reset.
- Reset mid-stream discards all in-flight beats. out_valid is low from the reset assertion onward.
- No combinational path from a, b, or op to any output.

## Test plan
- 0x3F800000 + 0x40000000, op=0 → result 0x40400000, flags 0, out_valid exactly 3 cycles after accept.
- 0x3F800000, 0x3F800000, op=1 → 0x00000000, flags 0. Also 0x40400000 − 0x3F800000 → 0x40000000.
- 0x3F800000 + 0x33800000 (tie) → 0x3F800000, inexact=1. 0x3F800001 + 0x33800000 → 0x3F800002, inexact=1.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow=1, inexact=1. 0x00800000 − 0x00800001 → 0x80000000, underflow=1.
- 0x7F800000 − 0x7F800000 → 0x7FC00000, invalid=1. 0x7FA00000 + 0x3F800000 → 0x7FC00000, invalid=1. 0x7FC00000 + 0x3F800000 → 0x7FC00000, invalid=0.
- Backpressure and reset:
  - Stream 8 back-to-back beats with out_ready low for cycles 4–7 → in_ready drops, all 8 results emerge in order, unchanged while stalled.
  - Assert reset with 3 beats in flight → out_valid=0 immediately, no stale beat after release.

Source files
------------

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: pipelined IEEE-754 add/subtract with a valid/ready stream.
// Operands are captured in p0, then unpacked/aligned (p1), added (p2), and
// normalised/rounded/packed into the output register (p3). One global enable
// stalls every stage together whenever the output beat is not taken.
module fp_addsub_pipe #(
  parameter  int EXP_WIDTH  = 8,
  parameter  int MANT_WIDTH = 23,
  localparam int WIDTH      = 1 + EXP_WIDTH + MANT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int E   = EXP_WIDTH;
  localparam int M   = MANT_WIDTH;
  localparam int XW  = M + 4;          // hidden + fraction + guard/round/sticky
  localparam int SW  = M + 5;          // XW plus carry
  localparam int LZW = $clog2(XW + 1);
  localparam int EW  = ((E > LZW) ? E : LZW) + 2;  // signed working exponent

  localparam logic [WIDTH-1:0]     QNAN = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
  localparam logic signed [EW-1:0] EMAX = {{(EW-E){1'b0}}, {E{1'b1}}};
  localparam logic signed [EW-1:0] ONE  = {{(EW-1){1'b0}}, 1'b1};

  // Right shift with every shifted-out bit folded into the sticky LSB.
  function automatic logic [XW-1:0] align_rs(input logic [XW-1:0] m, input logic [E-1:0] d);
    logic [XW-1:0] sh;
    logic [XW-1:0] lost;
    if (32'(d) >= 32'(XW - 1)) begin
      return {{(XW-1){1'b0}}, |m};
    end
    sh   = m >> d;
    lost = m & ~({XW{1'b1}} << d);
    return {sh[XW-1:1], sh[0] | (|lost)};
  endfunction

  // Leading-zero count; an all-zero input returns XW.
  function automatic logic [LZW-1:0] lzc(input logic [XW-1:0] v);
    logic [LZW-1:0] n;
    n = LZW'(XW);
    for (int i = 0; i < XW; i++) begin
      if (v[i]) n = LZW'(XW - 1 - i);
    end
    return n;
  endfunction

  // Round to nearest, ties to even; result keeps one extra bit for the carry.
  function automatic logic [M+1:0] round_rne(input logic [XW-1:0] m);
    logic up;
    up = m[2] & (m[1] | m[0] | m[3]);
    return {1'b0, m[XW-1:3]} + {{(M+1){1'b0}}, up};
  endfunction

  logic en;
  logic vld_p0_q, vld_p1_q, vld_p2_q, vld_p3_q;

  assign en        = ~vld_p3_q | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_p3_q;

  // Valid bits advance together under the global enable; reset empties the pipe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else if (en) begin
      vld_p0_q <= in_valid;
      vld_p1_q <= vld_p0_q;
      vld_p2_q <= vld_p1_q;
      vld_p3_q <= vld_p2_q;
    end
  end

  // ---- p0: operand capture ----
  logic [WIDTH-1:0] a_p0_q, b_p0_q;
  logic             op_p0_q;

  // Capture raw operands so no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (en) begin
      a_p0_q  <= a;
      b_p0_q  <= b;
      op_p0_q <= op;
    end
  end

  // ---- p0 -> p1: unpack, classify, swap, align ----
  logic          sa, sb, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, swap;
  logic [E-1:0]  ea, eb, x_exp, y_exp, d;
  logic [M-1:0]  fa, fb;
  logic [XW-1:0] ma, mb, x_man, y_man;

  assign sa     = a_p0_q[WIDTH-1];
  assign sb     = b_p0_q[WIDTH-1] ^ op_p0_q;
  assign ea     = a_p0_q[WIDTH-2:M];
  assign eb     = b_p0_q[WIDTH-2:M];
  assign fa     = a_p0_q[M-1:0];
  assign fb     = b_p0_q[M-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_nan  = (&ea) & (|fa);
  assign b_nan  = (&eb) & (|fb);
  assign a_inf  = (&ea) & ~(|fa);
  assign b_inf  = (&eb) & ~(|fb);
  // Denormals flush to zero: hidden bit and fraction both cleared.
  assign ma     = {~a_zero, fa & {M{~a_zero}}, 3'b000};
  assign mb     = {~b_zero, fb & {M{~b_zero}}, 3'b000};
  assign swap   = {eb, mb[XW-2:0]} > {ea, ma[XW-2:0]};
  assign x_exp  = swap ? eb : ea;
  assign y_exp  = swap ? ea : eb;
  assign x_man  = swap ? mb : ma;
  assign y_man  = swap ? ma : mb;
  assign d      = x_exp - y_exp;

  logic             spec_p1_d, inv_p1_d;
  logic [WIDTH-1:0] sres_p1_d;

  // NaN and infinity operands bypass the datapath with a fixed result.
  always_comb begin
    spec_p1_d = 1'b0;
    inv_p1_d  = 1'b0;
    sres_p1_d = QNAN;
    if (a_nan | b_nan) begin
      spec_p1_d = 1'b1;
      inv_p1_d  = (a_nan & ~fa[M-1]) | (b_nan & ~fb[M-1]);
    end else if (a_inf & b_inf) begin
      spec_p1_d = 1'b1;
      if (sa != sb) inv_p1_d = 1'b1;
      else          sres_p1_d = {sa, {E{1'b1}}, {M{1'b0}}};
    end else if (a_inf) begin
      spec_p1_d = 1'b1;
      sres_p1_d = {sa, {E{1'b1}}, {M{1'b0}}};
    end else if (b_inf) begin
      spec_p1_d = 1'b1;
      sres_p1_d = {sb, {E{1'b1}}, {M{1'b0}}};
    end
  end

  logic             spec_p1_q, inv_p1_q, sign_p1_q, esub_p1_q;
  logic [WIDTH-1:0] sres_p1_q;
  logic [E-1:0]     exp_p1_q;
  logic [XW-1:0]    xm_p1_q, ym_p1_q;

  // Stage 1 register: larger operand X and aligned smaller operand Y.
  always_ff @(posedge clk) begin
    if (en) begin
      spec_p1_q <= spec_p1_d;
      inv_p1_q  <= inv_p1_d;
      sres_p1_q <= sres_p1_d;
      sign_p1_q <= swap ? sb : sa;
      esub_p1_q <= sa ^ sb;
      exp_p1_q  <= x_exp;
      xm_p1_q   <= x_man;
      ym_p1_q   <= align_rs(y_man, d);
    end
  end

  // ---- p1 -> p2: magnitude add/subtract (X >= Y, never negative) ----
  logic [SW-1:0] sum_p2_d;

  assign sum_p2_d = esub_p1_q ? ({1'b0, xm_p1_q} - {1'b0, ym_p1_q})
                              : ({1'b0, xm_p1_q} + {1'b0, ym_p1_q});

  logic             spec_p2_q, inv_p2_q, sign_p2_q, esub_p2_q;
  logic [WIDTH-1:0] sres_p2_q;
  logic [E-1:0]     exp_p2_q;
  logic [SW-1:0]    sum_p2_q;

  // Stage 2 register: raw sum with carry bit.
  always_ff @(posedge clk) begin
    if (en) begin
      spec_p2_q <= spec_p1_q;
      inv_p2_q  <= inv_p1_q;
      sres_p2_q <= sres_p1_q;
      sign_p2_q <= sign_p1_q;
      esub_p2_q <= esub_p1_q;
      exp_p2_q  <= exp_p1_q;
      sum_p2_q  <= sum_p2_d;
    end
  end

  // ---- p2 -> p3: normalise, round, range check, pack ----
  logic signed [EW-1:0] e0, e1, e2;
  logic [LZW-1:0]       lz;
  logic [XW-1:0]        nm;
  logic [M+1:0]         mr;
  logic [M-1:0]         fr;
  logic [WIDTH-1:0]     res_p3_d;
  logic [3:0]           flg_p3_d;

  assign e0 = $signed({{(EW-E){1'b0}}, exp_p2_q});
  assign lz = lzc(sum_p2_q[XW-1:0]);

  // Normalisation, rounding and final result/flag selection.
  always_comb begin
    if (sum_p2_q[SW-1]) begin
      nm = {sum_p2_q[SW-1:2], |sum_p2_q[1:0]};
      e1 = e0 + ONE;
    end else begin
      nm = sum_p2_q[XW-1:0] << lz;
      e1 = e0 - $signed({{(EW-LZW){1'b0}}, lz});
    end
    mr = round_rne(nm);
    if (mr[M+1]) begin
      e2 = e1 + ONE;
      fr = mr[M:1];
    end else begin
      e2 = e1;
      fr = mr[M-1:0];
    end
    res_p3_d = {sign_p2_q, e2[E-1:0], fr};
    flg_p3_d = {3'b000, |nm[2:0]};
    if (spec_p2_q) begin
      res_p3_d = sres_p2_q;
      flg_p3_d = {inv_p2_q, 3'b000};
    end else if (sum_p2_q == '0) begin
      res_p3_d = {sign_p2_q & ~esub_p2_q, {(WIDTH-1){1'b0}}};
      flg_p3_d = 4'b0000;
    end else if (!e2[EW-1] && e2 >= EMAX) begin
      res_p3_d = {sign_p2_q, {E{1'b1}}, {M{1'b0}}};
      flg_p3_d = 4'b0101;
    end else if (e2[EW-1] || e2 == '0) begin
      res_p3_d = {sign_p2_q, {(WIDTH-1){1'b0}}};
      flg_p3_d = 4'b0011;
    end
  end

  // Output register: loads only real beats, holds while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
      flags  <= '0;
    end else if (en && vld_p2_q) begin
      result <= res_p3_d;
      flags  <= flg_p3_d;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe (binary32): directed cases, backpressure, reset
// mid-stream and randomized traffic scored against an exact-arithmetic model.
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, op, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_errors = 0;
  int n_pop    = 0;
  logic stall_seen = 1'b0;
  logic [35:0] exp_q[$];

  localparam logic [31:0] QNAN = 32'h7FC00000;

  fp_addsub_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Exact sum on wide integers, then a single round-to-nearest-even.
  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y, input logic o);
    logic sa, sb, an, bn, ai, bi, sgn, inx;
    logic [7:0] ea, eb;
    logic [22:0] fa, fb;
    logic [319:0] va, vb, mag, kept, rem, half;
    int p, sh, e;
    sa = x[31]; ea = x[30:23]; fa = x[22:0];
    sb = y[31] ^ o; eb = y[30:23]; fb = y[22:0];
    an = (ea == 8'hFF) && (fa != 0); bn = (eb == 8'hFF) && (fb != 0);
    ai = (ea == 8'hFF) && (fa == 0); bi = (eb == 8'hFF) && (fb == 0);
    if (an || bn) return {QNAN, (an && !fa[22]) || (bn && !fb[22]), 3'b000};
    if (ai && bi) return (sa != sb) ? {QNAN, 4'b1000} : {sa, 8'hFF, 23'h0, 4'h0};
    if (ai) return {sa, 8'hFF, 23'h0, 4'h0};
    if (bi) return {sb, 8'hFF, 23'h0, 4'h0};
    va = (ea == 0) ? '0 : (320'({1'b1, fa}) << (ea - 8'd1));
    vb = (eb == 0) ? '0 : (320'({1'b1, fb}) << (eb - 8'd1));
    if (sa == sb)      begin mag = va + vb; sgn = sa; end
    else if (va >= vb) begin mag = va - vb; sgn = sa; end
    else               begin mag = vb - va; sgn = sb; end
    if (mag == 0) return {(sa == sb) ? sa : 1'b0, 31'h0, 4'h0};
    p = 0;
    for (int i = 0; i < 320; i++) if (mag[i]) p = i;
    e = p - 22;
    inx = 1'b0;
    if (p > 23) begin
      sh   = p - 23;
      kept = mag >> sh;
      rem  = mag & ((320'd1 << sh) - 320'd1);
      half = 320'd1 << (sh - 1);
      inx  = (rem != 0);
      if (rem > half || (rem == half && kept[0])) kept = kept + 320'd1;
      if (kept[24]) begin kept = kept >> 1; e = e + 1; end
    end else begin
      kept = mag << (23 - p);
    end
    if (e >= 255) return {sgn, 8'hFF, 23'h0, 4'b0101};
    if (e <= 0)   return {sgn, 31'h0, 4'b0011};
    return {sgn, e[7:0], kept[22:0], 3'b000, inx};
  endfunction

  function automatic logic [31:0] rnd_fp(input int base);
    int e;
    case ($urandom_range(0, 11))
      0: return $urandom();
      1: case ($urandom_range(0, 8))
           0: return 32'h00000000;
           1: return 32'h80000000;
           2: return 32'h7F800000;
           3: return 32'hFF800000;
           4: return 32'h7FC00000;
           5: return 32'h7FA00000;
           6: return 32'($urandom_range(1, 8388607));
           7: return 32'h7F7FFFFF;
           default: return 32'h00800000;
         endcase
      default: begin
        e = base + int'($urandom_range(0, 40)) - 20;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        return {1'($urandom_range(0, 1)), 8'(e), 23'($urandom())};
      end
    endcase
  endfunction

  // Scoreboard/monitor: samples handshakes at the falling edge.
  initial begin
    logic        held_vld;
    logic [31:0] held_res;
    logic [3:0]  held_flg;
    logic [35:0] ex;
    held_vld = 1'b0; held_res = '0; held_flg = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        held_vld = 1'b0;
      end else begin
        if (held_vld) begin
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_result", result, held_res);
          chk("stall_flags", 32'(flags), 32'(held_flg));
        end
        held_vld = out_valid && !out_ready;
        held_res = result;
        held_flg = flags;
        if (in_valid && !in_ready) stall_seen = 1'b1;
        if (out_valid && out_ready) begin
          chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            ex = exp_q.pop_front();
            chk("sb_result", result, ex[35:4]);
            chk("sb_flags", 32'(flags), 32'(ex[3:0]));
            n_pop++;
          end
        end
        if (in_valid && in_ready) exp_q.push_back(model(a, b, op));
      end
    end
  end

  task automatic send(input logic [31:0] xa, input logic [31:0] xb, input logic xo);
    int w;
    a = xa; b = xb; op = xo; in_valid = 1'b1; w = 0;
    do begin @(negedge clk); w++; end while (!in_ready && w < 1000);
    if (w >= 1000) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_one(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                         input logic xo, input logic [31:0] er, input logic [3:0] ef);
    int lat;
    @(posedge clk); #1;
    send(xa, xb, xo);
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk({tag, "_latency"}, 32'(lat), 32'd3);
    chk({tag, "_result"}, result, er);
    chk({tag, "_flags"}, 32'(flags), 32'(ef));
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || out_valid) && w < 500) begin @(posedge clk); #1; w++; end
    if (w >= 500) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, seen, pop0;
    logic drv_done;
    logic [31:0] xa, xb;
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;

    run_one("add_1_2",   32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    run_one("sub_1_1",   32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
    run_one("sub_3_1",   32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000);
    run_one("tie_even",  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
    run_one("tie_odd",   32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001);
    run_one("overflow",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
    run_one("underflow", 32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0011);
    run_one("inf_m_inf", 32'h7F800000, 32'h7F800000, 1'b1, QNAN, 4'b1000);
    run_one("snan",      32'h7FA00000, 32'h3F800000, 1'b0, QNAN, 4'b1000);
    run_one("qnan",      32'h7FC00000, 32'h3F800000, 1'b0, QNAN, 4'b0000);
    run_one("nz_nz",     32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
    run_one("nz_pz",     32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0000);
    run_one("ninf_fin",  32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000);
    run_one("fin_m_inf", 32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000);
    drain();

    // Backpressure: 8 back-to-back beats, downstream stalls for four cycles.
    @(posedge clk); #1;
    pop0 = n_pop; stall_seen = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(rnd_fp(127), rnd_fp(127), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_in_ready_drop", 32'(stall_seen), 32'd1);
    chk("bp_count", 32'(n_pop - pop0), 32'd8);

    // Reset with three beats in flight and the first one stalled at the output.
    out_ready = 1'b0;
    send(32'h3F800000, 32'h40000000, 1'b0);
    send(32'h40400000, 32'h3F800000, 1'b1);
    send(32'h41200000, 32'h3F800000, 1'b0);
    seen = 0;
    while (!out_valid && seen < 20) begin @(posedge clk); #1; seen++; end
    chk("rs_pre_valid", 32'(out_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rs_out_valid", 32'(out_valid), 32'd0);
    chk("rs_in_ready", 32'(in_ready), 32'd1);
    chk("rs_result", result, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (out_valid) seen++; end
    chk("rs_no_stale", 32'(seen), 32'd0);

    // Randomized traffic with random gaps and random downstream stalls.
    pop0 = n_pop; drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          base = int'($urandom_range(1, 254));
          xa = rnd_fp(base);
          if ($urandom_range(0, 5) == 0) xb = xa ^ 32'($urandom_range(0, 255));
          else                           xb = rnd_fp(base);
          send(xa, xb, 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("rand_count", 32'(n_pop - pop0), 32'd300);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
